// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 constants, state encoding and round helper functions
package sha2_pkg;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_OUT} state_e;

   // Index 0 is a / H0; index 0 of the schedule window is the oldest word W[t].
   typedef logic [7:0][31:0]  hash_t;
   typedef logic [15:0][31:0] sched_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [31:0] IV_256 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] IV_224 [0:7] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
   import sha2_pkg::*;
(
   input  hash_t       st_i,
   input  logic [31:0] kt_i,
   input  logic [31:0] wt_i,
   output hash_t       st_o
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1   = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + kt_i + wt_i;
      t2   = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
      st_o = {st_i[6:4], st_i[3] + t1, st_i[2:0], t1 + t2};
   end

endmodule

// File: rtl/sha2_stream_core.sv
// rtl/sha2_stream_core.sv - streaming SHA-256/SHA-224 engine
// Takes padded 32-bit big-endian words, runs ROUNDS_PER_CYCLE rounds per clock, streams the digest.
module sha2_stream_core
   import sha2_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        mode,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  t_q, t_d;
   logic [2:0]  idx_q, idx_d;
   logic        mode_q, mode_d;
   logic        last_q, last_d;
   hash_t       h_q, h_d;
   hash_t       wk_q, wk_d;
   sched_t      w_q, w_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   hash_t       rnd_st;
   sched_t      rnd_w;
   logic [2:0]  last_idx;

   // Each stage consumes W[0] of its window and hands the shifted window on.
   for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
      hash_t      st_in, st_out;
      sched_t     w_in, w_out;
      logic [5:0] k_idx;
      if (i == 0) begin : g_first
         assign st_in = wk_q;
         assign w_in  = w_q;
      end else begin : g_next
         assign st_in = g_rnd[i-1].st_out;
         assign w_in  = g_rnd[i-1].w_out;
      end
      assign k_idx = t_q + 6'(i);
      assign w_out = {small_sigma1(w_in[14]) + w_in[9] + small_sigma0(w_in[1]) + w_in[0], w_in[15:1]};
      sha256_round u_round (
         .st_i (st_in),
         .kt_i (K[k_idx]),
         .wt_i (w_in[0]),
         .st_o (st_out)
      );
   end
   assign rnd_st = g_rnd[ROUNDS_PER_CYCLE-1].st_out;
   assign rnd_w  = g_rnd[ROUNDS_PER_CYCLE-1].w_out;

   assign last_idx = mode_q ? 3'd6 : 3'd7;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  if (in_valid && cnt_q == 4'd15) state_d = S_ROUND;
         S_ROUND: if (t_q == 6'(64 - ROUNDS_PER_CYCLE)) state_d = S_FINAL;
         S_FINAL: state_d = last_q ? S_OUT : S_LOAD;
         S_OUT:   if (out_ready && out_last_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_LOAD);
      busy     = (state_q != S_IDLE);
   end

   always_comb begin
      cnt_d       = cnt_q;
      t_d         = t_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      last_d      = last_q;
      h_d         = h_q;
      wk_d        = wk_q;
      w_d         = w_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      case (state_q)
         S_IDLE: if (start) begin
            mode_d = mode;
            last_d = 1'b0;
            cnt_d  = 4'd0;
            for (int j = 0; j < 8; j++) h_d[j] = mode ? IV_224[j] : IV_256[j];
         end
         S_LOAD: if (in_valid) begin
            w_d   = {in_data, w_q[15:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               last_d = in_last;
               wk_d   = h_q;
               t_d    = 6'd0;
            end
         end
         S_ROUND: begin
            wk_d = rnd_st;
            w_d  = rnd_w;
            t_d  = t_q + 6'(ROUNDS_PER_CYCLE);
         end
         S_FINAL: begin
            for (int j = 0; j < 8; j++) h_d[j] = h_q[j] + wk_q[j];
            if (last_q) begin
               out_valid_d = 1'b1;
               out_data_d  = h_q[0] + wk_q[0];
               out_last_d  = 1'b0;
               idx_d       = 3'd0;
            end
         end
         S_OUT: if (out_ready) begin
            if (out_last_q) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else begin
               idx_d      = idx_q + 3'd1;
               out_data_d = h_q[idx_q + 3'd1];
               out_last_d = ((idx_q + 3'd1) == last_idx);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         t_q         <= '0;
         idx_q       <= '0;
         mode_q      <= 1'b0;
         last_q      <= 1'b0;
         h_q         <= '0;
         wk_q        <= '0;
         w_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         t_q         <= t_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         last_q      <= last_d;
         h_q         <= h_d;
         wk_q        <= wk_d;
         w_q         <= w_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_sha2_stream_core.sv
// tb/tb_sha2_stream_core.sv - scoreboard bench for sha2_stream_core
// Unit 0 is built with one round per clock, unit 1 with four.
module tb_sha2_stream_core;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   localparam logic [31:0] BLK [3][16] = '{
      '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018},
      '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
      '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0}};

   localparam logic [31:0] DIG [3][8] = '{
      '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad},
      '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3, 32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000},
      '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039, 32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1}};

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  start_s, mode_s, in_valid_s, in_ready_s, in_last_s;
   logic [1:0]  out_valid_s, out_ready_s, out_last_s, busy_s;
   logic [31:0] in_data_s [2];
   logic [31:0] out_data_s [2];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   out_cnt [2];
   int   acc_cyc [2];
   int   rise_cyc [2];
   logic prev_stall [2];
   logic prev_ov [2];
   logic [31:0] prev_data [2];
   logic prev_last [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sha2_stream_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_s[0]), .mode(mode_s[0]),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]), .in_last(in_last_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
      .out_last(out_last_s[0]), .busy(busy_s[0]));

   sha2_stream_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .start(start_s[1]), .mode(mode_s[1]),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]), .in_last(in_last_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
      .out_last(out_last_s[1]), .busy(busy_s[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %08h required %08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual timeout required event", name);
   endtask

   function automatic int qsize(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   task automatic mon_unit(input int u);
      exp_t e;
      if (!reset_n) begin
         prev_stall[u] = 1'b0;
         prev_ov[u]    = 1'b0;
         return;
      end
      if (prev_stall[u]) begin
         check("stall_valid", 32'(out_valid_s[u]), 32'd1);
         check("stall_data", out_data_s[u], prev_data[u]);
         check("stall_last", 32'(out_last_s[u]), 32'(prev_last[u]));
      end
      if (out_valid_s[u] && !prev_ov[u]) rise_cyc[u] = cyc;
      if (out_valid_s[u] && out_ready_s[u]) begin
         if (qsize(u) == 0) begin
            check("unexpected_word", out_data_s[u], 32'h0);
            errors += (out_data_s[u] === 32'h0) ? 1 : 0;
         end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            check("digest_word", out_data_s[u], e.data);
            check("out_last", 32'(out_last_s[u]), 32'(e.last));
         end
         out_cnt[u]++;
      end
      prev_stall[u] = out_valid_s[u] && !out_ready_s[u];
      prev_ov[u]    = out_valid_s[u];
      prev_data[u]  = out_data_s[u];
      prev_last[u]  = out_last_s[u];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_msg(input int u, input logic m);
      start_s[u] = 1'b1;
      mode_s[u]  = m;
      tick();
      start_s[u] = 1'b0;
   endtask

   task automatic push_word(input int u, input logic [31:0] d, input logic l, input int gap, input logic first);
      int n = 0;
      in_valid_s[u] = 1'b0;
      repeat (gap) tick();
      in_valid_s[u] = 1'b1;
      in_data_s[u]  = d;
      in_last_s[u]  = l;
      @(negedge clk);
      while (!in_ready_s[u] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready_s[u]) fail_now("accept_timeout");
      else if (first) acc_cyc[u] = cyc;
      tick();
      in_valid_s[u] = 1'b0;
      in_last_s[u]  = 1'b0;
   endtask

   task automatic send_block(input int u, input int b, input logic last, input logic first, input logic gaps);
      for (int i = 0; i < 16; i++)
         push_word(u, BLK[b][i], last && (i == 15), gaps ? int'($urandom_range(0, 3)) : 0, first && (i == 0));
   endtask

   task automatic expect_digest(input int u, input int d, input int nw);
      exp_t e;
      for (int i = 0; i < nw; i++) begin
         e.data = DIG[d][i];
         e.last = (i == nw - 1);
         if (u == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic wait_done(input int u);
      int n = 0;
      while (qsize(u) != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (qsize(u) != 0) fail_now("digest_timeout");
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid_s[u]), 32'd0);
      check("idle_busy", 32'(busy_s[u]), 32'd0);
      tick();
   endtask

   task automatic check_reset_outputs(input int u);
      check("rst_in_ready", 32'(in_ready_s[u]), 32'd0);
      check("rst_out_valid", 32'(out_valid_s[u]), 32'd0);
      check("rst_out_data", out_data_s[u], 32'd0);
      check("rst_out_last", 32'(out_last_s[u]), 32'd0);
      check("rst_busy", 32'(busy_s[u]), 32'd0);
   endtask

   initial begin
      int base;
      int n;
      reset_n     = 1'b0;
      start_s     = '0;
      mode_s      = '0;
      in_valid_s  = '0;
      in_last_s   = '0;
      out_ready_s = 2'b11;
      in_data_s   = '{32'h0, 32'h0};
      out_cnt     = '{0, 0};
      acc_cyc     = '{0, 0};
      rise_cyc    = '{0, 0};
      prev_stall  = '{1'b0, 1'b0};
      prev_ov     = '{1'b0, 1'b0};
      prev_data   = '{32'h0, 32'h0};
      prev_last   = '{1'b0, 1'b0};
      fork
         forever begin
            @(negedge clk);
            mon_unit(0);
            mon_unit(1);
         end
      join_none

      repeat (3) tick();
      @(negedge clk);
      check_reset_outputs(0);
      check_reset_outputs(1);
      tick();
      reset_n = 1'b1;
      tick();

      // SHA-256 "abc" with full-rate input: 81 cycles from first accept to out_valid
      expect_digest(0, 0, 8);
      start_msg(0, 1'b0);
      send_block(0, 0, 1'b1, 1'b1, 1'b0);
      wait_done(0);
      check("latency_r1", 32'(rise_cyc[0] - acc_cyc[0]), 32'd81);

      // SHA-224 "abc": seven words only
      expect_digest(0, 1, 7);
      start_msg(0, 1'b1);
      send_block(0, 0, 1'b1, 1'b1, 1'b0);
      wait_done(0);

      // two-block message, in_last held high on the first block's early words is ignored
      expect_digest(0, 2, 8);
      start_msg(0, 1'b0);
      for (int i = 0; i < 16; i++) push_word(0, BLK[1][i], (i < 15), 0, i == 0);
      send_block(0, 2, 1'b1, 1'b0, 1'b0);
      wait_done(0);

      // two-block message with random input gaps and a 10-cycle output stall
      expect_digest(0, 2, 8);
      start_msg(0, 1'b0);
      send_block(0, 1, 1'b0, 1'b1, 1'b1);
      send_block(0, 2, 1'b1, 1'b0, 1'b1);
      base = out_cnt[0];
      n = 0;
      while (out_cnt[0] < base + 3 && n < 400) begin
         tick();
         n++;
      end
      out_ready_s[0] = 1'b0;
      repeat (10) tick();
      out_ready_s[0] = 1'b1;
      wait_done(0);

      // four rounds per clock: 16 + 16 + 1 cycles to the first out_valid
      expect_digest(1, 0, 8);
      start_msg(1, 1'b0);
      send_block(1, 0, 1'b1, 1'b1, 1'b0);
      wait_done(1);
      check("latency_r4", 32'(rise_cyc[1] - acc_cyc[1]), 32'd33);

      // reset in the middle of ROUND aborts without emitting anything
      start_msg(0, 1'b0);
      send_block(0, 0, 1'b1, 1'b1, 1'b0);
      repeat (10) tick();
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_outputs(0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // fresh run after reset; a start pulse while busy must not switch to SHA-224
      expect_digest(0, 0, 8);
      start_msg(0, 1'b0);
      send_block(0, 0, 1'b1, 1'b1, 1'b0);
      repeat (5) tick();
      start_msg(0, 1'b1);
      mode_s[0] = 1'b0;
      wait_done(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
